// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte driver between
// NUM_REQ byte-stream requesters, with an optional idle gap between packets.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned BYTE_LEN   = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*BYTE_LEN-1:0]   req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          drv_data_ready,
   output logic [BYTE_LEN-1:0]           drv_data,
   input  logic                          drv_done,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PKT,
      S_GAP
   } state_t;

   state_t              r_state;
   logic [IW-1:0]       r_grant_id;
   logic [IW-1:0]       r_last_grant;
   logic [GW-1:0]       r_gap_cnt;
   logic                r_busy;

   logic [IW-1:0]       w_idx;
   logic [IW-1:0]       w_winner;
   logic                w_any;
   logic                w_in_pkt;
   logic                w_sel_valid;
   logic                w_sel_last;
   logic [BYTE_LEN-1:0] w_sel_data;
   logic [NUM_REQ-1:0]  w_done;

   // Scan from farthest to nearest offset so the nearest valid requester
   // after last_grant overwrites any farther candidate.
   always_comb begin
      w_idx    = '0;
      w_winner = '0;
      w_any    = 1'b0;
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         w_idx = IW'((32'(r_last_grant) + k) % NUM_REQ);
         if (req_valid[w_idx]) begin
            w_winner = w_idx;
            w_any    = 1'b1;
         end
      end
   end

   assign w_in_pkt = (r_state == S_PKT);

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      w_done      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == r_grant_id) begin
            w_sel_valid = req_valid[i];
            w_sel_last  = req_last[i];
            w_sel_data  = req_data[i*BYTE_LEN +: BYTE_LEN];
            w_done[i]   = w_in_pkt & drv_done;
         end
      end
   end

   assign drv_data_ready = w_in_pkt & w_sel_valid;
   assign drv_data       = w_in_pkt ? w_sel_data : '0;
   assign req_done       = w_done;
   assign busy           = r_busy;
   assign grant_id       = r_grant_id;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= IW'(NUM_REQ - 1);
         r_gap_cnt    <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant_id   <= w_winner;
                  r_last_grant <= w_winner;
                  r_state      <= S_PKT;
                  r_busy       <= 1'b1;
               end
            end
            S_PKT: begin
               if (drv_done && w_sel_last) begin
                  if (GAP_CYCLES > 0) begin
                     r_gap_cnt <= GW'(GAP_CYCLES - 1);
                     r_state   <= S_GAP;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple driver
// responder that answers each presented byte with a done pulse.
module tb_uart_tx_arbiter;

   localparam int unsigned NR      = 4;
   localparam int unsigned GAP     = 5;
   localparam int unsigned BL      = 8;
   localparam int unsigned DRV_LAT = 3;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NR-1:0]        req_valid;
   logic [NR*BL-1:0]     req_data;
   logic [NR-1:0]        req_last;
   logic [NR-1:0]        req_done;
   logic                 drv_data_ready;
   logic [BL-1:0]        drv_data;
   logic                 drv_done;
   logic                 busy;
   logic [1:0]           grant_id;

   typedef struct {
      int unsigned id;
      logic [7:0]  d;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .GAP_CYCLES (GAP),
      .BYTE_LEN   (BL)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_data       (req_data),
      .req_last       (req_last),
      .req_done       (req_done),
      .drv_data_ready (drv_data_ready),
      .drv_data       (drv_data),
      .drv_done       (drv_done),
      .busy           (busy),
      .grant_id       (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned id, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.d  = d;
      sb.push_back(e);
   endtask

   task automatic set_req(input int unsigned id, input logic [7:0] d, input logic last);
      req_data[id*BL +: BL] = d;
      req_last[id]          = last;
   endtask

   // Returns on the negedge where req_done[id] is seen, or after a bounded wait.
   task automatic wait_done(input int unsigned id, input string tag);
      int unsigned n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_done[id] && n < 200);
      chk(tag, 32'(req_done[id]), 32'd1);
   endtask

   task automatic wait_drain();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("sb_drain", 32'(sb.size()), 32'd0);
   endtask

   // Driver model: done pulse after DRV_LAT consecutive cycles of data_ready.
   initial begin
      int unsigned cnt;
      cnt      = 0;
      drv_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n || drv_done) begin
            drv_done = 1'b0;
            cnt      = 0;
         end else if (drv_data_ready) begin
            cnt++;
            if (cnt == DRV_LAT) begin
               drv_done = 1'b1;
               cnt      = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Scoreboard consumer: every accepted byte is matched against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && drv_done) begin
            chk("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("drv_data", 32'(drv_data), 32'(e.d));
               chk("req_done_onehot", 32'(req_done), 32'(1) << e.id);
               chk("grant_at_done", 32'(grant_id), e.id);
            end
         end else begin
            chk("req_done_quiet", 32'(req_done), 32'd0);
         end
      end
   end

   initial begin
      int unsigned bad;
      reset_n   = 1'b0;
      req_valid = '1;
      req_last  = '1;
      req_data  = '0;
      for (int unsigned i = 0; i < NR; i++) set_req(i, 8'hA0 + 8'(i), 1'b1);

      // Reset with every requester asserting valid
      repeat (3) tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(drv_data_ready), 32'd0);
      chk("rst_data", 32'(drv_data), 32'd0);
      chk("rst_done", 32'(req_done), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("first_grant", 32'(grant_id), 32'd0);
      chk("first_ready", 32'(drv_data_ready), 32'd1);
      chk("first_busy", 32'(busy), 32'd1);
      chk("first_data", 32'(drv_data), 32'hA0);

      // Round-robin over requesters 0, 1, 3 with single-byte packets
      tick();
      reset_n   = 1'b0;
      req_valid = 4'b1011;
      tick();
      tick();
      for (int r = 0; r < 2; r++) begin
         push(0, 8'hA0);
         push(1, 8'hA1);
         push(3, 8'hA3);
      end
      reset_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         wait_done(0, "rr_done0");
         tick();
         wait_done(1, "rr_done1");
         tick();
         wait_done(3, "rr_done3");
         tick();
      end
      req_valid = '0;
      wait_drain();

      // Gap between packets
      set_req(0, 8'hB0, 1'b1);
      set_req(1, 8'hB1, 1'b1);
      push(0, 8'hB0);
      push(1, 8'hB1);
      req_valid = 4'b0011;
      bad = 0;
      do begin
         @(negedge clk);
         bad++;
      end while (!drv_done && bad < 100);
      chk("gap_first_done", 32'(drv_done), 32'd1);
      tick();
      req_valid[0] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         else @(negedge clk);
         chk("gap_busy", 32'(busy), 32'd1);
         chk("gap_ready", 32'(drv_data_ready), 32'd0);
      end
      @(negedge clk);
      chk("gap_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("gap_next_grant", 32'(grant_id), 32'd1);
      chk("gap_next_ready", 32'(drv_data_ready), 32'd1);
      wait_done(1, "gap_done1");
      tick();
      req_valid = '0;
      wait_drain();

      // Packet atomicity: requester 2 holds the line while 0 waits
      set_req(2, 8'h10, 1'b0);
      set_req(0, 8'h55, 1'b1);
      push(2, 8'h10);
      push(2, 8'h11);
      push(2, 8'h12);
      push(0, 8'h55);
      req_valid = 4'b0101;
      wait_done(2, "atom_b0");
      tick();
      set_req(2, 8'h11, 1'b0);
      wait_done(2, "atom_b1");
      tick();
      set_req(2, 8'h12, 1'b1);
      wait_done(2, "atom_b2");
      tick();
      req_valid[2] = 1'b0;
      wait_done(0, "atom_r0");
      tick();
      req_valid = '0;
      wait_drain();

      // Mid-packet stall by the grantee while another requester waits
      set_req(1, 8'h21, 1'b0);
      set_req(3, 8'h33, 1'b1);
      push(1, 8'h21);
      push(1, 8'h22);
      push(3, 8'h33);
      req_valid = 4'b1010;
      wait_done(1, "stall_b0");
      tick();
      req_valid[1] = 1'b0;
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (drv_data_ready !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1) bad++;
      end
      chk("stall_hold_violations", bad, 32'd0);
      tick();
      set_req(1, 8'h22, 1'b1);
      req_valid[1] = 1'b1;
      wait_done(1, "stall_b1");
      tick();
      req_valid[1] = 1'b0;
      wait_done(3, "stall_r3");
      tick();
      req_valid = '0;
      wait_drain();

      // Reset mid-packet drops the grant and restores requester-0 priority
      set_req(2, 8'h40, 1'b0);
      push(2, 8'h40);
      req_valid = 4'b0100;
      wait_done(2, "mrst_b0");
      tick();
      set_req(2, 8'h41, 1'b0);
      reset_n   = 1'b0;
      req_valid = 4'b1010;
      set_req(1, 8'h61, 1'b1);
      set_req(3, 8'h63, 1'b1);
      repeat (3) tick();
      @(negedge clk);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_ready", 32'(drv_data_ready), 32'd0);
      push(1, 8'h61);
      push(3, 8'h63);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("mrst_idle_ready", 32'(drv_data_ready), 32'd0);
      @(negedge clk);
      chk("mrst_grant", 32'(grant_id), 32'd1);
      chk("mrst_ready_on", 32'(drv_data_ready), 32'd1);
      wait_done(1, "mrst_r1");
      tick();
      req_valid[1] = 1'b0;
      wait_done(3, "mrst_r3");
      tick();
      req_valid = '0;
      wait_drain();
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter between `NUM_REQ` byte-stream requesters with packet-granular round-robin arbitration. A grant is held from a packet's first byte to its `last` byte, so packets are never interleaved on the serial line. An optional idle gap is inserted between packets. The block sits between the framing and debug sources and the `uart_driver` instance, forwarding that driver's `done` pulse back to the owning requester as a per-requester consume strobe.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `GAP_CYCLES`, default 0: idle clk cycles forced after each packet's last byte is consumed; 0 means no gap.
- `BYTE_LEN`, default from `params.vh` (8): byte width.

Ports (`IW = clog2(NUM_REQ)`):
- `clk`, in, 1: sole clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, `NUM_REQ`: requester *i* has a byte presented.
- `req_data`, in, `NUM_REQ*BYTE_LEN`: byte of requester *i* at bits `[i*BYTE_LEN +: BYTE_LEN]`.
- `req_last`, in, `NUM_REQ`: presented byte is the final byte of its packet.
- `req_done`, out, `NUM_REQ`: one-cycle pulse; requester *i*'s byte was consumed.
- `drv_data_ready`, out, 1: to driver `data_ready`.
- `drv_data`, out, `BYTE_LEN`: to driver `data`.
- `drv_done`, in, 1: from driver `done`.
- `busy`, out, 1: a grant is active or a gap is running.
- `grant_id`, out, `IW`: index of the current or most recent grantee.

## Operation
Requester contract:
- Hold `req_valid`, `req_data` and `req_last` stable until `req_done[i]`.
- A requester may lower `req_valid` only between packets, or while waiting mid-packet.

States:
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching cyclically from `last_grant+1`.
  - Register `grant_id <= winner` and `last_grant <= winner`, then go to **PKT**.
  - Otherwise stay in IDLE.
- **PKT**
  - `drv_data_ready = req_valid[grant_id]`, `drv_data = req_data[grant_id]`. Both are combinational muxes from the registered `grant_id`.
  - `req_done[grant_id] = drv_done`, combinational; all other `req_done` bits are 0.
  - On `drv_done`, sample `req_last[grant_id]`:
    - If set and `GAP_CYCLES > 0`, load the gap counter with `GAP_CYCLES-1` and go to **GAP**.
    - If set and `GAP_CYCLES == 0`, go to **IDLE**.
    - If clear, stay in PKT.
  - If the grantee drops `req_valid` mid-packet, the grant is held and the driver idles. No other requester is served. There is no timeout.
- **GAP**
  - Outputs are as in IDLE.
  - The counter decrements each cycle; at 0 go to **IDLE**.
  - The counter width is `clog2(GAP_CYCLES+1)` and it must not wrap.

Outside PKT:
- `drv_data_ready = 0`, `drv_data = 0`, `req_done = 0`.
- A `drv_done` arriving outside PKT is ignored.

Other rules:
- `busy` is 1 in PKT and GAP, 0 in IDLE.
- New `req_valid` assertions during PKT or GAP only affect the next IDLE decision.
- A single-byte packet (`last` on the first byte) is legal.
- Reset:
  - State goes to IDLE and `grant_id` to 0.
  - `last_grant` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - The gap counter goes to 0.
  - All outputs go to 0 and `req_done` goes to all zeros.
  - A reset mid-packet drops the grant with no `req_done`; the driver shares the reset.

## Timing
- Arbitration latency:
  - `req_valid` high in IDLE at cycle *t* gives `grant_id` valid and `drv_data_ready` high at *t+1*.
  - From PKT, the end of the last byte to the next grant takes `GAP_CYCLES+1` cycles: the exit on `drv_done`, then the gap, then one IDLE decision cycle.
- `req_done` is coincident with `drv_done`. The requester presents its next byte from the following cycle.
- The driver's next sample is one baud frame later, so there is no bubble beyond the driver's own framing.
- No combinational path from `req_valid` to `grant_id`; there is one from `drv_done` to `req_done`.

## Test plan
- **Reset:** hold `reset_n=0` for 3 cycles with all `req_valid=1` → all outputs 0, `busy=0`. On release, the first grant is to requester 0 at the next cycle.
- **Round-robin:** requesters 0, 1 and 3 each send one-byte packets 0xA0, 0xA1 and 0xA3, continuously valid → drv byte order 0xA0, 0xA1, 0xA3, 0xA0 and so on; each `req_done[i]` pulses exactly once per byte.
- **Packet atomicity:** requester 2 sends 0x10, 0x11, 0x12 (last on 0x12) while requester 0 is valid throughout → all three bytes go out before `grant_id` becomes 0; `req_done[0]` stays 0 during the packet.
- **Gap:** `GAP_CYCLES=5`, two requesters with one-byte packets → exactly 5 cycles of `busy=1` with `drv_data_ready=0` after the first `drv_done`; the second grant comes 6 cycles after it.
- **Mid-packet stall:** grantee drops `req_valid` for 2000 cycles between bytes while another requester is valid → `drv_data_ready=0` and `grant_id` unchanged throughout; the packet resumes intact.
- **Reset mid-packet:** assert `reset_n=0` after byte 1 of 3 → no further `req_done`; after release, arbitration restarts from requester 0 priority.
